// File: rtl/rijndael_sbox_seq.sv
// Byte-serial AddRoundKey + SubBytes engine around one masked S-box.
// Masks come from a free-running LFSR and are stripped before each result byte is written.
module rijndael_sbox_seq #(
  parameter int          NBYTES    = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] din,
  input  logic [8*NBYTES-1:0] key,
  input  logic                mask_en,
  input  logic                seed_load,
  input  logic [15:0]         seed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] dout,
  output logic                busy
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx;
  logic [15:0]     lfsr;
  logic [W-1:0]    din_r, key_r, dout_q;
  logic [7:0]      a_r, m_in_r, m_out_r;
  logic [7:0]      m_in, m_out, sb_out;
  logic            accept, lfsr_fb;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, t;
    p = '0;
    t = x;
    for (int unsigned i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 by square-and-multiply; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t;
    t = gf_mul(gf_mul(x, x), x);        // x^3
    t = gf_mul(gf_mul(t, t), x);        // x^7
    t = gf_mul(gf_mul(t, t), x);        // x^15
    t = gf_mul(gf_mul(t, t), x);        // x^31
    t = gf_mul(gf_mul(t, t), x);        // x^63
    t = gf_mul(gf_mul(t, t), x);        // x^127
    return gf_mul(t, t);                // x^254
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign m_in     = lfsr[7:0]  & {8{mask_en}};
  assign m_out    = lfsr[15:8] & {8{mask_en}};
  assign sb_out   = sbox(a_r ^ m_in_r) ^ m_out_r;
  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == APPLY) || (state_q == CAPTURE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;
  assign dout      = dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = APPLY;
      APPLY:   state_d = CAPTURE;
      CAPTURE: state_d = (idx == LAST) ? DONE : APPLY;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (state_q == IDLE && seed_load && seed != '0) begin
      lfsr <= seed;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      din_r   <= '0;
      key_r   <= '0;
      dout_q  <= '0;
      a_r     <= '0;
      m_in_r  <= '0;
      m_out_r <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            din_r <= din;
            key_r <= key;
            idx   <= '0;
          end
        end
        APPLY: begin
          a_r     <= din_r[{idx, 3'b000} +: 8] ^ key_r[{idx, 3'b000} +: 8] ^ m_in;
          m_in_r  <= m_in;
          m_out_r <= m_out;
        end
        CAPTURE: begin
          dout_q[{idx, 3'b000} +: 8] <= sb_out ^ m_out_r;
          if (idx != LAST) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rijndael_sbox_seq.sv
// Directed-vector bench for rijndael_sbox_seq with NBYTES=16.
module tb_rijndael_sbox_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [127:0] din, key;
  logic         mask_en, seed_load;
  logic [15:0]  seed;
  logic         out_valid, out_ready;
  logic [127:0] dout;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] T1_DIN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] T1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] T1_EXP  = 128'h63cab7040953d051cd60e0e7ba70e18c;
  localparam logic [127:0] ALL63   = 128'h63636363636363636363636363636363;
  localparam logic [127:0] B0ED    = 128'h636363636363636363636363636363ed;

  rijndael_sbox_seq #(.NBYTES(16), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .key(key), .mask_en(mask_en), .seed_load(seed_load), .seed(seed),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_and_wait(input logic [127:0] d, input logic [127:0] k,
                                output int lat, output logic [127:0] trace);
    din = d;
    key = k;
    in_valid = 1'b1;
    trace = '0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
      if ((lat % 2) == 1 && lat < 32) trace[8*((lat-1)/2) +: 8] = dut.a_r;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] d, input logic [127:0] k,
                           output logic [127:0] res, output int lat, output logic [127:0] trace);
    start_and_wait(d, k, lat, trace);
    res = dout;
    release_out();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (dout !== '0)          begin errors++; $display("FAIL reset_dout got %h exp 0", dout); end
    checks++; if (dut.lfsr !== 16'hACE1) begin errors++; $display("FAIL reset_lfsr got %h exp ace1", dut.lfsr); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unmasked();
    logic [127:0] r, tr;
    int lat;
    mask_en = 1'b0;
    run_block(T1_DIN, T1_KEY, r, lat, tr);
    checks++; if (r !== T1_EXP) begin errors++; $display("FAIL t1_dout got %h exp %h", r, T1_EXP); end
    checks++; if (lat !== 32)   begin errors++; $display("FAIL t1_latency got %0d exp 32", lat); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t1_idle_after got %b exp 1", in_ready); end
  endtask

  task automatic test_masked_seeds();
    logic [15:0]  seeds [3] = '{16'h0001, 16'hBEEF, 16'h5A5A};
    logic [127:0] traces [3];
    logic [127:0] r;
    int lat;
    mask_en = 1'b1;
    for (int s = 0; s < 3; s++) begin
      seed = seeds[s];
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      run_block(T1_DIN, T1_KEY, r, lat, traces[s]);
      checks++; if (r !== T1_EXP) begin errors++; $display("FAIL t2_dout_seed%0d got %h exp %h", s, r, T1_EXP); end
      checks++; if (lat !== 32)   begin errors++; $display("FAIL t2_latency_seed%0d got %0d exp 32", s, lat); end
    end
    checks++; if (traces[0] === traces[1]) begin errors++; $display("FAIL t2_operand_diff01 got %h exp differ from %h", traces[1], traces[0]); end
    checks++; if (traces[1] === traces[2]) begin errors++; $display("FAIL t2_operand_diff12 got %h exp differ from %h", traces[2], traces[1]); end
  endtask

  task automatic test_edge_bytes();
    logic [127:0] r, tr;
    int lat;
    mask_en = 1'b1;
    run_block('0, '0, r, lat, tr);
    checks++; if (r !== ALL63) begin errors++; $display("FAIL t3_zero got %h exp %h", r, ALL63); end
    run_block(128'h53, '0, r, lat, tr);
    checks++; if (r !== B0ED)  begin errors++; $display("FAIL t3_b53 got %h exp %h", r, B0ED); end
  endtask

  task automatic test_backpressure();
    logic [127:0] tr;
    int lat;
    bit stable;
    mask_en = 1'b0;
    start_and_wait(T1_DIN, T1_KEY, lat, tr);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t4_reach_done got %b exp 1", out_valid); end
    din = '1;
    in_valid = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid !== 1'b1 || dout !== T1_EXP || in_ready !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL t4_hold got ov=%b rdy=%b dout=%h exp ov=1 rdy=0 dout=%h", out_valid, in_ready, dout, T1_EXP); end
    in_valid = 1'b0;
    release_out();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t4_ov_cleared got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL t4_idle got %b exp 1", in_ready); end
    tick(); tick();
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL t4_not_queued got busy=%b exp 0", busy); end
    checks++; if (dout !== T1_EXP)    begin errors++; $display("FAIL t4_dout_held_idle got %h exp %h", dout, T1_EXP); end
  endtask

  task automatic test_abort();
    logic [127:0] r, tr;
    int lat, n;
    mask_en = 1'b1;
    din = ALL63;
    key = T1_KEY;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (dut.idx != 4'd7 && n < 100) begin tick(); n++; end
    checks++; if (dut.idx !== 4'd7) begin errors++; $display("FAIL t5_reach_idx7 got %0d exp 7", dut.idx); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL t5_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL t5_in_ready got %b exp 1", in_ready); end
    checks++; if (dut.lfsr !== 16'hACE1) begin errors++; $display("FAIL t5_lfsr got %h exp ace1", dut.lfsr); end
    checks++; if (dout !== '0)           begin errors++; $display("FAIL t5_dout got %h exp 0", dout); end
    tick();
    rst = 1'b0;
    tick();
    run_block(T1_DIN, T1_KEY, r, lat, tr);
    checks++; if (r !== T1_EXP) begin errors++; $display("FAIL t5_next_block got %h exp %h", r, T1_EXP); end
    checks++; if (lat !== 32)   begin errors++; $display("FAIL t5_next_latency got %0d exp 32", lat); end
  endtask

  task automatic test_seed();
    logic [15:0] exp_l;
    logic [127:0] tr;
    int lat;
    rst = 1'b1;
    seed_load = 1'b1;
    seed = 16'h0000;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (dut.lfsr !== 16'h59C3) begin errors++; $display("FAIL t6_seed_zero got %h exp 59c3", dut.lfsr); end
    seed = 16'h1234;
    tick();
    seed_load = 1'b0;
    checks++; if (dut.lfsr !== 16'h1234) begin errors++; $display("FAIL t6_seed_load got %h exp 1234", dut.lfsr); end
    mask_en = 1'b1;
    din = T1_DIN;
    key = T1_KEY;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    seed_load = 1'b1;
    seed = 16'hFFFF;
    repeat (4) tick();
    seed_load = 1'b0;
    exp_l = 16'h1234;
    for (int i = 0; i < 5; i++) exp_l = lfsr_step(exp_l);
    checks++; if (dut.lfsr !== exp_l) begin errors++; $display("FAIL t6_busy_ignored got %h exp %h", dut.lfsr, exp_l); end
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    checks++; if (dout !== T1_EXP) begin errors++; $display("FAIL t6_block got %h exp %h", dout, T1_EXP); end
    release_out();
    tr = '0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    din = '0;
    key = '0;
    mask_en = 1'b0;
    seed_load = 1'b0;
    seed = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_unmasked();
    test_masked_seeds();
    test_edge_bytes();
    test_backpressure();
    test_abort();
    test_seed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
